// File: rtl/pru1_cpu_ocimem_ctrl.sv
// Debugger word access engine: runs JTAG-issued reads and writes against the
// CPU on-chip debug memory port.
// Latency: pulse at N -> request at N+1 -> DONE at N+2 -> monitor_ready from N+3 (zero-wait memory).
// Backpressure: mem_waitrequest holds the request; it is aborted after TIMEOUT_CYCLES stalled cycles.
//
// Ports:
//   clk, reset                          rising-edge clock, synchronous active-high reset
//   jdo, take_action_ocimem_a/b,        decoded debug-wrapper commands, already in the clk domain
//   take_no_action_ocimem_a
//   mem_address/_writedata/_write/_read debug memory request side
//   mem_waitrequest, mem_readdata       debug memory response side
//   MonDReg, monitor_ready,             results returned to the wrapper capture logic
//   monitor_error
//
// Optional feature: define PRU1_OCIMEM_AUTOINC_EN to post-increment the address
// after every successful access (block transfers from a single address load).
module pru1_cpu_ocimem_ctrl #(
    parameter int ADDR_W         = 9,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    output logic [ADDR_W-1:0] mem_address,
    output logic [31:0]       mem_writedata,
    output logic              mem_write,
    output logic              mem_read,
    input  logic              mem_waitrequest,
    input  logic [31:0]       mem_readdata,
    output logic [31:0]       MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD   = 2'd2,
        DONE = 2'd3
    } state_t;

    // Stall count at which the current stalled cycle is the last one allowed.
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] address;
    logic [7:0]        wait_cnt;
    logic              any_cmd;
    logic              stall_expired;

    // jdo bits outside the address and data fields carry nothing for this block.
    logic unused_jdo_bits;
    assign unused_jdo_bits = ^{jdo[37:35], jdo[2:0]};

    assign any_cmd       = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
    assign stall_expired = mem_waitrequest && (wait_cnt >= TMO_LAST);

    // Requests decode straight from state so a reset drops them one cycle later
    // and read/write can never overlap.
    assign mem_write     = (state == WR);
    assign mem_read      = (state == RD);
    assign mem_address   = address;
    assign mem_writedata = MonDReg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                // a > b > no_action; lower-priority pulses are silently dropped.
                if (take_action_ocimem_a) begin
                    state_nxt = IDLE;
                end else if (take_action_ocimem_b) begin
                    state_nxt = WR;
                end else if (take_no_action_ocimem_a) begin
                    state_nxt = RD;
                end
            end
            WR, RD: begin
                if (!mem_waitrequest || stall_expired) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

`ifdef PRU1_OCIMEM_AUTOINC_EN
    // Remembers whether the access that led into DONE was aborted.
    logic timed_out;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            address       <= '0;
            MonDReg       <= '0;
            monitor_ready <= 1'b0;
            monitor_error <= 1'b0;
            wait_cnt      <= '0;
`ifdef PRU1_OCIMEM_AUTOINC_EN
            timed_out     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (take_action_ocimem_a) begin
                        address       <= jdo[ADDR_W+16:17];
                        monitor_ready <= 1'b0;
                        if (jdo[34]) begin
                            monitor_error <= 1'b0;
                        end
                    end else if (take_action_ocimem_b) begin
                        MonDReg       <= jdo[34:3];
                        monitor_ready <= 1'b0;
                    end else if (take_no_action_ocimem_a) begin
                        monitor_ready <= 1'b0;
                    end
                end
                WR, RD: begin
                    // A command while busy is an overrun; the access carries on.
                    if (any_cmd) begin
                        monitor_error <= 1'b1;
                    end
                    if (!mem_waitrequest) begin
                        if (state == RD) begin
                            MonDReg <= mem_readdata;
                        end
`ifdef PRU1_OCIMEM_AUTOINC_EN
                        timed_out <= 1'b0;
`endif
                    end else if (stall_expired) begin
                        monitor_error <= 1'b1;
`ifdef PRU1_OCIMEM_AUTOINC_EN
                        timed_out     <= 1'b1;
`endif
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                DONE: begin
                    if (any_cmd) begin
                        monitor_error <= 1'b1;
                    end
                    monitor_ready <= 1'b1;
                    wait_cnt      <= '0;
`ifdef PRU1_OCIMEM_AUTOINC_EN
                    if (!timed_out) begin
                        address <= address + 1'b1;
                    end
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pru1_cpu_ocimem_ctrl.sv
// Directed self-checking bench for pru1_cpu_ocimem_ctrl (TIMEOUT_CYCLES=8).
// Inputs change and outputs are sampled 1ns after each rising edge.
// Expected addresses follow PRU1_OCIMEM_AUTOINC_EN when it is defined.
module tb_pru1_cpu_ocimem_ctrl;

    localparam int ADDR_W = 9;

`ifdef PRU1_OCIMEM_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    logic              clk;
    logic              reset;
    logic [37:0]       jdo;
    logic              take_action_ocimem_a;
    logic              take_action_ocimem_b;
    logic              take_no_action_ocimem_a;
    logic [ADDR_W-1:0] mem_address;
    logic [31:0]       mem_writedata;
    logic              mem_write;
    logic              mem_read;
    logic              mem_waitrequest;
    logic [31:0]       mem_readdata;
    logic [31:0]       MonDReg;
    logic              monitor_ready;
    logic              monitor_error;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] exp_addr;

    pru1_cpu_ocimem_ctrl #(
        .ADDR_W(ADDR_W),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .jdo(jdo),
        .take_action_ocimem_a(take_action_ocimem_a),
        .take_action_ocimem_b(take_action_ocimem_b),
        .take_no_action_ocimem_a(take_no_action_ocimem_a),
        .mem_address(mem_address),
        .mem_writedata(mem_writedata),
        .mem_write(mem_write),
        .mem_read(mem_read),
        .mem_waitrequest(mem_waitrequest),
        .mem_readdata(mem_readdata),
        .MonDReg(MonDReg),
        .monitor_ready(monitor_ready),
        .monitor_error(monitor_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [37:0] mk_load(input logic [8:0] addr, input logic clr);
        logic [37:0] v;
        v        = '0;
        v[25:17] = addr;
        v[34]    = clr;
        return v;
    endfunction

    function automatic logic [37:0] mk_wr(input logic [31:0] data);
        logic [37:0] v;
        v       = '0;
        v[34:3] = data;
        return v;
    endfunction

    task automatic pulse(input logic a, input logic b, input logic n, input logic [37:0] d);
        jdo                     = d;
        take_action_ocimem_a    = a;
        take_action_ocimem_b    = b;
        take_no_action_ocimem_a = n;
        tick();
        take_action_ocimem_a    = 1'b0;
        take_action_ocimem_b    = 1'b0;
        take_no_action_ocimem_a = 1'b0;
    endtask

    initial begin
        reset                   = 1'b1;
        jdo                     = '0;
        take_action_ocimem_a    = 1'b0;
        take_action_ocimem_b    = 1'b0;
        take_no_action_ocimem_a = 1'b0;
        mem_waitrequest         = 1'b0;
        mem_readdata            = '0;
        tick();
        tick();

        // Reset state
        check("rst_mem_read",  32'(mem_read),      32'h0);
        check("rst_mem_write", 32'(mem_write),     32'h0);
        check("rst_mondreg",   MonDReg,            32'h0);
        check("rst_ready",     32'(monitor_ready), 32'h0);
        check("rst_error",     32'(monitor_error), 32'h0);
        check("rst_address",   32'(mem_address),   32'h0);
        reset = 1'b0;
        tick();

        // Load 0x010, write 0xDEADBEEF, read it back
        pulse(1'b1, 1'b0, 1'b0, mk_load(9'h010, 1'b0));
        check("ld_address", 32'(mem_address), 32'h010);
        pulse(1'b0, 1'b1, 1'b0, mk_wr(32'hDEADBEEF));
        check("wr_req",       32'(mem_write),   32'h1);
        check("wr_no_read",   32'(mem_read),    32'h0);
        check("wr_address",   32'(mem_address), 32'h010);
        check("wr_data",      mem_writedata,    32'hDEADBEEF);
        tick();
        check("wr_done_req",   32'(mem_write),     32'h0);
        check("wr_done_ready", 32'(monitor_ready), 32'h0);
        tick();
        check("wr_ready", 32'(monitor_ready), 32'h1);
        exp_addr = AUTOINC ? 32'h011 : 32'h010;
        mem_readdata = 32'hDEADBEEF;
        pulse(1'b0, 1'b0, 1'b1, 38'h0);
        check("rd_req",     32'(mem_read),    32'h1);
        check("rd_address", 32'(mem_address), exp_addr);
        check("rd_ready_lo", 32'(monitor_ready), 32'h0);
        tick();
        tick();
        check("rd_data",  MonDReg,             32'hDEADBEEF);
        check("rd_ready", 32'(monitor_ready),  32'h1);

        // Read with 5 wait states
        pulse(1'b1, 1'b0, 1'b0, mk_load(9'h040, 1'b0));
        mem_waitrequest = 1'b1;
        mem_readdata    = 32'h12345678;
        pulse(1'b0, 1'b0, 1'b1, 38'h0);
        for (int i = 0; i < 5; i++) begin
            check("ws_read_held", 32'(mem_read),    32'h1);
            check("ws_addr_held", 32'(mem_address), 32'h040);
            tick();
        end
        mem_waitrequest = 1'b0;
        check("ws_accept_read", 32'(mem_read), 32'h1);
        tick();
        check("ws_done_read", 32'(mem_read), 32'h0);
        tick();
        check("ws_data",  MonDReg,            32'h12345678);
        check("ws_error", 32'(monitor_error), 32'h0);
        check("ws_ready", 32'(monitor_ready), 32'h1);

        // Timeout after 8 stalled cycles
        pulse(1'b1, 1'b0, 1'b0, mk_load(9'h080, 1'b0));
        mem_waitrequest = 1'b1;
        mem_readdata    = 32'hFFFFFFFF;
        pulse(1'b0, 1'b0, 1'b1, 38'h0);
        for (int i = 0; i < 8; i++) begin
            check("to_read_held", 32'(mem_read), 32'h1);
            tick();
        end
        check("to_req_dropped", 32'(mem_read),      32'h0);
        check("to_error",       32'(monitor_error), 32'h1);
        tick();
        check("to_ready",   32'(monitor_ready), 32'h1);
        check("to_mondreg", MonDReg,            32'h12345678);
        check("to_no_inc",  32'(mem_address),   32'h080);
        mem_waitrequest = 1'b0;
        pulse(1'b1, 1'b0, 1'b0, mk_load(9'h000, 1'b1));
        check("clr_error", 32'(monitor_error), 32'h0);

        // Overrun: read pulse while a write is stalled
        pulse(1'b1, 1'b0, 1'b0, mk_load(9'h020, 1'b0));
        mem_waitrequest = 1'b1;
        pulse(1'b0, 1'b1, 1'b0, mk_wr(32'hCAFEF00D));
        check("ov_write", 32'(mem_write), 32'h1);
        pulse(1'b0, 1'b0, 1'b1, 38'h0);
        check("ov_error",      32'(monitor_error), 32'h1);
        check("ov_no_read",    32'(mem_read),      32'h0);
        check("ov_write_held", 32'(mem_write),     32'h1);
        mem_waitrequest = 1'b0;
        tick();
        check("ov_done_write", 32'(mem_write), 32'h0);
        check("ov_done_read",  32'(mem_read),  32'h0);
        tick();
        check("ov_ready",   32'(monitor_ready), 32'h1);
        check("ov_data",    MonDReg,            32'hCAFEF00D);
        check("ov_idle_rd", 32'(mem_read),      32'h0);

        // Address wrap on the top word
        pulse(1'b1, 1'b0, 1'b0, mk_load(9'h1FF, 1'b1));
        pulse(1'b0, 1'b1, 1'b0, mk_wr(32'h00000001));
        check("wrap_wr_addr", 32'(mem_address), 32'h1FF);
        tick();
        tick();
        exp_addr = AUTOINC ? 32'h000 : 32'h1FF;
        check("wrap_addr", 32'(mem_address), exp_addr);

        // Simultaneous a and b: only the address load happens
        pulse(1'b1, 1'b1, 1'b0, mk_load(9'h055, 1'b0));
        check("pri_addr",     32'(mem_address),   32'h055);
        check("pri_no_write", 32'(mem_write),     32'h0);
        check("pri_mondreg",  MonDReg,            32'h00000001);
        check("pri_ready",    32'(monitor_ready), 32'h0);
        tick();
        check("pri_still_idle", 32'(mem_write), 32'h0);

        // Reset in the middle of a stalled write
        pulse(1'b1, 1'b0, 1'b0, mk_load(9'h033, 1'b0));
        mem_waitrequest = 1'b1;
        pulse(1'b0, 1'b1, 1'b0, mk_wr(32'h00000077));
        check("mr_write", 32'(mem_write), 32'h1);
        reset = 1'b1;
        tick();
        check("mr_write_drop", 32'(mem_write),     32'h0);
        check("mr_read",       32'(mem_read),      32'h0);
        check("mr_mondreg",    MonDReg,            32'h0);
        check("mr_ready",      32'(monitor_ready), 32'h0);
        check("mr_error",      32'(monitor_error), 32'h0);
        check("mr_address",    32'(mem_address),   32'h0);
        reset           = 1'b0;
        mem_waitrequest = 1'b0;
        tick();
        check("mr_idle_write", 32'(mem_write), 32'h0);
        check("mr_idle_ready", 32'(monitor_ready), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pru1_cpu_ocimem_ctrl.md
Name: pru1_cpu_ocimem_ctrl

Overview:
- Sysclk-domain consumer of the JTAG debug wrapper's decoded actions: take_action_ocimem_a/b, take_no_action_ocimem_a and jdo.
- Executes debugger word reads and writes against the CPU's on-chip debug memory port through a waitrequest handshake.
- Returns MonDReg, monitor_ready and monitor_error to the wrapper's TCK-side capture logic.
- Sits directly downstream of the debug wrapper and upstream of the debug RAM/ROM arbiter.

Parameters:
- ADDR_W, 9, word-address width of the debug memory port.
- TIMEOUT_CYCLES, 255, maximum cycles mem_waitrequest may stall before the access is aborted; range 1..255 (8-bit counter).

Ports:
- clk  in  1  system clock; all logic is rising-edge.
- reset  in  1  synchronous, active-high reset.
- jdo  in  38  JTAG data word, already synchronised to clk.
- take_action_ocimem_a  in  1  one-cycle pulse: load address, optionally clear error.
- take_action_ocimem_b  in  1  one-cycle pulse: write jdo[34:3] at the current address.
- take_no_action_ocimem_a  in  1  one-cycle pulse: read at the current address.
- mem_address  out  ADDR_W  word address to debug memory.
- mem_writedata  out  32  write data.
- mem_write  out  1  write request, held until accepted.
- mem_read  out  1  read request, held until accepted.
- mem_waitrequest  in  1  stall; the request is accepted in the cycle this is low.
- mem_readdata  in  32  read data, valid in the acceptance cycle of a read.
- MonDReg  out  32  last write data or read result.
- monitor_ready  out  1  last access completed; no access is in flight.
- monitor_error  out  1  sticky error: timeout or command overrun.

Behaviour:
- Reset state: state=IDLE, address=0, MonDReg=0, monitor_ready=0, monitor_error=0, mem_read=0, mem_write=0, timeout counter=0. mem_writedata follows MonDReg.
- Reset asserted mid-access drops the request the next cycle. The access is not completed.
- Command decode applies only in IDLE. If more than one pulse arrives in the same cycle, priority is a > b > no_action_a; lower-priority pulses are discarded without error.
- take_action_ocimem_a:
  - address <= jdo[ADDR_W+16:17].
  - If jdo[34]=1, monitor_error <= 0.
  - monitor_ready <= 0.
  - State stays IDLE.
- take_action_ocimem_b:
  - MonDReg <= jdo[34:3].
  - monitor_ready <= 0.
  - Next state is WR; mem_write asserts in the cycle after the pulse.
- take_no_action_ocimem_a:
  - monitor_ready <= 0.
  - Next state is RD; mem_read asserts in the cycle after the pulse.
- WR/RD states:
  - Request and address are held stable while mem_waitrequest=1, and the timeout counter increments each stalled cycle.
  - On the cycle with mem_waitrequest=0 the request is accepted. For a read, MonDReg <= mem_readdata. Next state is DONE.
  - When the counter reaches TIMEOUT_CYCLES while still stalled: drop the request, monitor_error <= 1, MonDReg unchanged, next state DONE.
- DONE (single cycle):
  - monitor_ready <= 1.
  - Counter cleared.
  - Address post-increment per the optional feature; applied only on a successful access, not after a timeout.
  - Next state is IDLE.
- Latency: for zero-wait memory, pulse at cycle N gives request at N+1, accept at N+1, DONE at N+2, and monitor_ready=1 from N+3.
- Any command pulse arriving in WR, RD or DONE is ignored and sets monitor_error <= 1 (overrun). The in-flight access continues unaffected.
- Address arithmetic is modulo 2^ADDR_W; the maximum address wraps to 0.
- mem_read and mem_write are never asserted together.

Optional Feature:
- Macro: PRU1_OCIMEM_AUTOINC_EN.
- Defined: address <= address+1 (wrapping) in DONE after every successful read or write. This allows block transfers with a single address load.
- Undefined: address changes only on take_action_ocimem_a. DONE performs no increment.

Test Plan:
- Load, write, read back: load address 0x010, write data 0xDEADBEEF, then read with memory model returning 0xDEADBEEF -> mem_address=0x010 on the write; MonDReg=0xDEADBEEF; monitor_ready=1 three cycles after each pulse; with AUTOINC_EN the read goes to 0x011, without it the read goes to 0x010.
- Wait states: waitrequest high for 5 cycles on a read returning 0x12345678 -> mem_read and mem_address held 5 cycles; MonDReg=0x12345678; monitor_error=0.
- Timeout: waitrequest stuck high with TIMEOUT_CYCLES=8 -> request drops after 8 stalled cycles; monitor_error=1; monitor_ready=1; address not incremented. Next, load with jdo[34]=1 -> monitor_error=0.
- Overrun: read pulse issued while WR is stalled -> monitor_error=1; no mem_read asserted; the write completes normally.
- Wrap and priority: with AUTOINC_EN, load address 0x1FF and write -> address becomes 0x000. Simultaneous a and b pulses -> only the address load occurs; no mem_write.
- Mid-access reset: reset asserted during a stalled write -> next cycle mem_write=0, all outputs at reset values, state IDLE.
